// File: rtl/status_tracker.sv
// Per-player health/guard tracker: edge-detected hurt/block events, guard regen,
// sticky KO and a global freeze while any player is KO'd.
module status_tracker #(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned HP_MAX       = 3,
  parameter int unsigned BLOCK_MAX    = 3,
  parameter int unsigned REGEN_FRAMES = 60
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             frame_tick,
  input  logic                             round_start,
  input  logic [2*NUM_PLAYERS-1:0]         stunmode,
  output logic [NUM_PLAYERS*HP_MAX-1:0]    health_bar,
  output logic [NUM_PLAYERS*BLOCK_MAX-1:0] block_bar,
  output logic [NUM_PLAYERS-1:0]           ko,
  output logic                             game_over,
  output logic [NUM_PLAYERS-1:0]           health_lost,
  output logic [NUM_PLAYERS-1:0]           guard_break
);

  localparam int unsigned HW = $clog2(HP_MAX + 1);
  localparam int unsigned GW = $clog2(BLOCK_MAX + 1);
  localparam int unsigned RW = $clog2(REGEN_FRAMES + 1);

  localparam logic [1:0] STUN_HURT  = 2'b01;
  localparam logic [1:0] STUN_BLOCK = 2'b10;

  localparam logic [HW-1:0] HEALTH_FULL = HW'(HP_MAX);
  localparam logic [GW-1:0] GUARD_FULL  = GW'(BLOCK_MAX);
  localparam logic [RW-1:0] REGEN_LAST  = RW'(REGEN_FRAMES - 1);

  logic [NUM_PLAYERS-1:0][HW-1:0] health, health_nxt;
  logic [NUM_PLAYERS-1:0][GW-1:0] guard, guard_nxt;
  logic [NUM_PLAYERS-1:0][RW-1:0] regen, regen_nxt;
  logic [2*NUM_PLAYERS-1:0]       prev_stun;
  logic [NUM_PLAYERS-1:0]         ko_nxt, lost_nxt, brk_nxt;
  logic [NUM_PLAYERS-1:0]         hurt_ev, block_ev;

  assign game_over = |ko;

  // Edge detection: an event fires only on entry into a stun code.
  always_comb begin
    hurt_ev  = '0;
    block_ev = '0;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      hurt_ev[p]  = (stunmode[2*p +: 2] == STUN_HURT)  && (prev_stun[2*p +: 2] != STUN_HURT);
      block_ev[p] = (stunmode[2*p +: 2] == STUN_BLOCK) && (prev_stun[2*p +: 2] != STUN_BLOCK);
    end
  end

  // Next-state for counters, KO and pulses; round reload wins over events.
  always_comb begin
    health_nxt = health;
    guard_nxt  = guard;
    regen_nxt  = regen;
    ko_nxt     = ko;
    lost_nxt   = '0;
    brk_nxt    = '0;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      if (round_start) begin
        health_nxt[p] = HEALTH_FULL;
        guard_nxt[p]  = GUARD_FULL;
        regen_nxt[p]  = '0;
        ko_nxt[p]     = 1'b0;
      end else if (!game_over) begin
        // A block with no guard left chips through as a hurt.
        if ((hurt_ev[p] || (block_ev[p] && guard[p] == GW'(0))) && health[p] != HW'(0)) begin
          health_nxt[p] = health[p] - HW'(1);
          lost_nxt[p]   = 1'b1;
          if (health[p] == HW'(1)) begin
            ko_nxt[p] = 1'b1;
          end
        end
        if (block_ev[p]) begin
          regen_nxt[p] = '0;
          if (guard[p] > GW'(1)) begin
            guard_nxt[p] = guard[p] - GW'(1);
          end else if (guard[p] == GW'(1)) begin
            guard_nxt[p] = '0;
            brk_nxt[p]   = 1'b1;
          end
        end else if (guard[p] == GUARD_FULL) begin
          regen_nxt[p] = '0;
        end else if (frame_tick) begin
          if (regen[p] == REGEN_LAST) begin
            guard_nxt[p] = guard[p] + GW'(1);
            regen_nxt[p] = '0;
          end else begin
            regen_nxt[p] = regen[p] + RW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      health      <= {NUM_PLAYERS{HEALTH_FULL}};
      guard       <= {NUM_PLAYERS{GUARD_FULL}};
      regen       <= '0;
      ko          <= '0;
      health_lost <= '0;
      guard_break <= '0;
      prev_stun   <= '0;
    end else begin
      health      <= health_nxt;
      guard       <= guard_nxt;
      regen       <= regen_nxt;
      ko          <= ko_nxt;
      health_lost <= lost_nxt;
      guard_break <= brk_nxt;
      prev_stun   <= stunmode;
    end
  end

  // Thermometer decode of the registered counters for the HUD.
  always_comb begin
    health_bar = '0;
    block_bar  = '0;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      for (int i = 0; i < int'(HP_MAX); i++) begin
        health_bar[p*int'(HP_MAX) + i] = (health[p] > HW'(i));
      end
      for (int i = 0; i < int'(BLOCK_MAX); i++) begin
        block_bar[p*int'(BLOCK_MAX) + i] = (guard[p] > GW'(i));
      end
    end
  end

endmodule
